// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: one countdown timer shared by NUM_REQ requesters.
// The owner is picked round-robin in IDLE and the count runs down on tick.
// The owner gets a one-cycle done pulse when the count expires. It can also
// abort by dropping its req while the timer is running.
// Optional macro SHARED_TIMER_FIXED_PRIORITY_EN: lowest index always wins and
// the round-robin pointer is removed.
module shared_timer_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] duration,
  input  logic                     tick,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         remaining
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   remaining_q, remaining_d;

  logic [PTR_W-1:0]   winner;
  logic [WIDTH-1:0]   dur_sel;
  logic               owner_req;

`ifndef SHARED_TIMER_FIXED_PRIORITY_EN
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     owner_idx, owner_next;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     off;
  logic [PTR_W:0]       sum;

  // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_REQ'(req_dbl >> rr_ptr_q);
    off     = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_rot[i]) off = PTR_W'(i);
    end
    sum    = {1'b0, rr_ptr_q} + {1'b0, off};
    winner = (sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(sum - (PTR_W+1)'(NUM_REQ))
                                          : sum[PTR_W-1:0];
  end

  // Index of the current owner and the slot after it, for the next search start.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q[i]) owner_idx = PTR_W'(i);
    end
    owner_next = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
  end
`else
  // Fixed-priority pick: lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req[i]) winner = PTR_W'(i);
    end
  end
`endif

  // Select the winner's duration slice; it is only used at the grant edge.
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == PTR_W'(i)) dur_sel = duration[i*WIDTH +: WIDTH];
    end
  end

  // Owner still requesting; req bits of non-owners are masked off.
  always_comb owner_req = |(req & grant_q);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    busy_d      = busy_q;
    remaining_d = remaining_q;
`ifndef SHARED_TIMER_FIXED_PRIORITY_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          remaining_d = dur_sel;
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          grant_d     = '0;
          remaining_d = '0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
`ifndef SHARED_TIMER_FIXED_PRIORITY_EN
          rr_ptr_d    = owner_next;
`endif
        end else if (remaining_q == '0) begin
          done_d  = grant_q;
          state_d = ST_DONE;
        end else if (tick) begin
          remaining_d = remaining_q - WIDTH'(1);
        end
      end
      ST_DONE: begin
        grant_d     = '0;
        remaining_d = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
`ifndef SHARED_TIMER_FIXED_PRIORITY_EN
        rr_ptr_d    = owner_next;
`endif
      end
      default: begin
        grant_d     = '0;
        remaining_d = '0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      remaining_q <= remaining_d;
    end
  end

`ifndef SHARED_TIMER_FIXED_PRIORITY_EN
  // Round-robin search start pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;

endmodule
